// File: rtl/cout_tx_pkg.sv
// Shared definitions for the COUT serial transmitter: TX state encoding and frame sizes.
// Frame size depends on COUT_TX_PARITY_EN (8E1 when defined, 8N1 otherwise).
package cout_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } tx_state_e;

  localparam int unsigned DATA_BITS      = 8;
  localparam int unsigned FRAME_BITS_8N1 = 10;
  localparam int unsigned FRAME_BITS_8E1 = 11;

`ifdef COUT_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = FRAME_BITS_8E1;
`else
  localparam int unsigned FRAME_BITS = FRAME_BITS_8N1;
`endif

endpackage

// File: rtl/cout_tx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered count and full/empty flags.
// Push is ignored when full and pop is ignored when empty.
module cout_tx_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_c_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push  = push_i && !full_q;
  assign do_pop   = pop_i && !empty_q;
  assign head_c_o = mem_q[rd_ptr_q];
  assign count_o  = count_q;
  assign full_o   = full_q;
  assign empty_o  = empty_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Simultaneous push and pop leave the occupancy unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

endmodule

// File: rtl/cout_tx.sv
// COUT output stage: buffers core bytes in a FIFO and serialises them as async frames on tx.
// Define COUT_TX_PARITY_EN for 8E1 frames (even parity bit); default build is 8N1.
module cout_tx
  import cout_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         wr_valid,
  input  logic [7:0]                   wr_data,
  output logic                         wr_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT    = 3'(DATA_BITS - 1);

  tx_state_e     state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q, busy_q;
`ifdef COUT_TX_PARITY_EN
  logic          parity_q;
`endif

  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_head;
  logic       push_c, pop_c, baud_done_c, next_idle_c;

  assign push_c   = wr_valid && !fifo_full;
  assign wr_ready = !fifo_full;
  assign tx       = tx_q;
  assign busy     = busy_q;

  cout_tx_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (reset_n),
    .push_i    (push_c),
    .wr_data_i (wr_data),
    .pop_i     (pop_c),
    .head_c_o  (fifo_head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // A new frame is fetched from IDLE or at the last cycle of STOP (back-to-back frames).
  always_comb begin
    baud_done_c = (baud_q == '0);
    pop_c       = 1'b0;
    next_idle_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        pop_c       = !fifo_empty;
        next_idle_c = fifo_empty;
      end
      ST_STOP: begin
        if (baud_done_c) begin
          pop_c       = !fifo_empty;
          next_idle_c = fifo_empty;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef COUT_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      // Going idle implies no pop, so the FIFO stays empty unless this edge pushes.
      busy_q <= !next_idle_c || push_c || !fifo_empty;
      unique case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (pop_c) begin
            state_q  <= ST_START;
            shift_q  <= fifo_head;
            baud_q   <= BAUD_RELOAD;
            tx_q     <= 1'b0;
`ifdef COUT_TX_PARITY_EN
            parity_q <= ^fifo_head;
`endif
          end
        end
        ST_START: begin
          if (baud_done_c) begin
            state_q <= ST_DATA;
            bit_q   <= '0;
            baud_q  <= BAUD_RELOAD;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        ST_DATA: begin
          if (baud_done_c) begin
            baud_q <= BAUD_RELOAD;
            if (bit_q == LAST_BIT) begin
`ifdef COUT_TX_PARITY_EN
              state_q <= ST_PARITY;
              tx_q    <= parity_q;
`else
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 3'(1);
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
`ifdef COUT_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_done_c) begin
            state_q <= ST_STOP;
            baud_q  <= BAUD_RELOAD;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (baud_done_c) begin
            if (pop_c) begin
              state_q  <= ST_START;
              shift_q  <= fifo_head;
              baud_q   <= BAUD_RELOAD;
              tx_q     <= 1'b0;
`ifdef COUT_TX_PARITY_EN
              parity_q <= ^fifo_head;
`endif
            end else begin
              state_q <= ST_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cout_tx.sv
// Self-checking bench for cout_tx: queue-based line model compared every cycle, plus directed frames.
module tb_cout_tx;
  import cout_tx_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CPB   = 4;
  localparam int unsigned FB    = FRAME_BITS;

`ifdef COUT_TX_PARITY_EN
  localparam bit PAR = 1'b1;
  bit f41 [FB] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1};
  bit f07 [FB] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
`else
  localparam bit PAR = 1'b0;
  bit f41 [FB] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
`endif

  logic                      clock    = 1'b0;
  logic                      reset_n  = 1'b0;
  logic                      wr_valid = 1'b0;
  logic [7:0]                wr_data  = 8'h00;
  logic                      wr_ready, tx, busy;
  logic [$clog2(DEPTH):0]    fifo_count;

  int checks   = 0;
  int failures = 0;
  int max_cnt  = 0;

  always #5 clock = ~clock;

  cout_tx #(
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // Reference: queue of accepted bytes and a queue of future line levels, one entry per cycle.
  logic [7:0] m_fifo [$];
  bit         m_wave [$];
  logic [7:0] m_b;
  bit         m_rdy;

  function automatic void add_bit(input bit v);
    for (int i = 0; i < int'(CPB); i++) m_wave.push_back(v);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_fifo.delete();
      m_wave.delete();
    end else begin
      m_rdy = (m_fifo.size() != DEPTH);
      if (m_wave.size() != 0) void'(m_wave.pop_front());
      if (m_wave.size() == 0 && m_fifo.size() != 0) begin
        m_b = m_fifo.pop_front();
        add_bit(1'b0);
        for (int i = 0; i < 8; i++) add_bit(m_b[i]);
        if (PAR) add_bit(^m_b);
        add_bit(1'b1);
      end
      if (wr_valid && m_rdy) m_fifo.push_back(wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    chk("tx", 32'(tx), (m_wave.size() == 0) ? 32'd1 : 32'(m_wave[0]));
    chk("busy", 32'(busy), 32'((m_wave.size() != 0) || (m_fifo.size() != 0)));
    chk("fifo_count", 32'(fifo_count), 32'(m_fifo.size()));
    chk("wr_ready", 32'(wr_ready), 32'(m_fifo.size() != DEPTH));
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
  endtask

  // Hold wr_valid until the byte is accepted; returns the number of stalled cycles.
  task automatic send(input logic [7:0] b, output int waited);
    waited   = 0;
    wr_valid = 1'b1;
    wr_data  = b;
    while (m_fifo.size() == DEPTH && waited < 500) begin
      tick();
      waited++;
    end
    chk("send_timeout", 32'(waited < 500), 32'd1);
    tick();
    wr_valid = 1'b0;
    wr_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_wave.size() != 0 || m_fifo.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < 3000), 32'd1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rec [$];
    int w;

    // Reset held, then 100 idle cycles.
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (100) tick();

    // Single byte 0x41: frame starts one edge after acceptance.
    send(8'h41, w);
    rec.delete();
    for (int i = 0; i < int'(FB * CPB); i++) begin
      tick();
      rec.push_back(tx);
    end
    for (int k = 0; k < int'(FB); k++)
      for (int j = 0; j < int'(CPB); j++)
        chk("frame41_bit", 32'(rec[k * CPB + j]), 32'(f41[k]));
    tick();
    chk("frame41_busy_end", 32'(busy), 32'd0);
    chk("frame41_tx_end", 32'(tx), 32'd1);

`ifdef COUT_TX_PARITY_EN
    // Parity frame for 0x07 (odd number of ones -> parity 1).
    wait_idle();
    send(8'h07, w);
    rec.delete();
    for (int i = 0; i < int'(FB * CPB); i++) begin
      tick();
      rec.push_back(tx);
    end
    for (int k = 0; k < int'(FB); k++)
      for (int j = 0; j < int'(CPB); j++)
        chk("frame07_bit", 32'(rec[k * CPB + j]), 32'(f07[k]));
    tick();
    chk("frame07_busy_end", 32'(busy), 32'd0);
`endif

    // Backpressure: six consecutive bytes into a depth-4 FIFO.
    wait_idle();
    for (int i = 0; i < 5; i++) send(8'($urandom), w);
    chk("bp_full_count", 32'(fifo_count), 32'(DEPTH));
    chk("bp_ready_low", 32'(wr_ready), 32'd0);
    send(8'($urandom), w);
    chk("bp_stall_cycles", 32'(w), 32'(FB * CPB - 3));
    wait_idle();

    // Reset during data bit 3 of 0xFF with two bytes queued.
    send(8'hFF, w);
    send(8'hAA, w);
    send(8'h55, w);
    repeat (16) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_count", 32'(fifo_count), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(wr_ready), 32'd1);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (60) tick();

    // Reset during a start bit: tx must rise without a clock edge.
    send(8'h00, w);
    repeat (2) tick();
    chk("rst_start_pre_tx", 32'(tx), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_start_tx", 32'(tx), 32'd1);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (20) tick();

    // Wrap-around: 20 bytes with random gaps.
    max_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(8'(i), w);
    end
    wait_idle();
    chk("wrap_max_count", 32'(max_cnt <= int'(DEPTH)), 32'd1);
    chk("wrap_idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
